// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port A, secondary master B and data-memory signals shared by the arbiter
interface dmem_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_stall;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_rdata, a_stall, b_ack, b_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_rdata, a_stall, b_ack, b_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority data-memory arbiter (A over B) with B starvation guard
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {B_IDLE, B_ACK} b_state_t;
  b_state_t          b_state, b_state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic [DATA_W-1:0] b_rdata_q;
  logic              b_elig, grant_a, grant_b, granted, we, starved;
  always_comb begin
    starved     = starve_cnt == CNT_W'(STARVE_MAX);
    b_elig      = bus.b_req & (b_state == B_IDLE);
    grant_b     = b_elig & (~bus.a_req | starved);
    grant_a     = bus.a_req & ~grant_b;
    granted     = grant_a | grant_b;
    we          = grant_b ? bus.b_we : bus.a_we;
    b_state_nxt = grant_b ? B_ACK : B_IDLE;
    starve_nxt  = (grant_b | ~b_elig) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      b_state    <= B_IDLE;
      starve_cnt <= '0;
      b_rdata_q  <= '0;
    end else begin
      b_state    <= b_state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_b) b_rdata_q <= bus.b_we ? '0 : bus.mem_rdata;
    end
  end
  assign bus.mem_addr  = grant_b ? bus.b_addr : grant_a ? bus.a_addr : '0;
  assign bus.mem_wdata = grant_b ? bus.b_wdata : grant_a ? bus.a_wdata : '0;
  assign bus.mem_read  = granted & ~we;
  assign bus.mem_write = granted & we;
  assign bus.a_rdata   = (grant_a & ~bus.a_we) ? bus.mem_rdata : '0;
  assign bus.a_stall   = bus.a_req & ~grant_a;
  // a reset overlapping the ack cycle suppresses the pulse, so the access is never reported
  assign bus.b_ack     = (b_state == B_ACK) & reset;
  assign bus.b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized arbiter test against a transaction-level reference model
module tb_dmem_arbiter;
  localparam int SM = 2;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(SM), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  bit m_ack = 0, a_hold = 0, b_hold = 0;
  int m_lost = 0;
  logic [31:0] m_brd = 0;
  assign bus.mem_rdata = bus.mem_addr < 256 ? mem[bus.mem_addr[7:2]] : '0;
  always @(posedge clk)
    if (bus.mem_write && bus.mem_addr < 256) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  function automatic logic [31:0] mrd(input logic [31:0] ad);
    return ad < 256 ? ref_mem[ad[7:2]] : 32'h0;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // who owns the memory this cycle, from the priority and starvation rules
  function automatic void decide(output bit be, output bit bw, output bit aw);
    be = bus.b_req && !m_ack;
    bw = be && (!bus.a_req || m_lost >= SM);
    aw = bus.a_req && !bw;
  endfunction
  always @(posedge clk) begin : model
    bit be, bw, aw;
    logic [31:0] rd;
    decide(be, bw, aw);
    rd = bus.b_we ? 32'h0 : mrd(bus.b_addr);
    if (bw && bus.b_we && bus.b_addr < 256) ref_mem[bus.b_addr[7:2]] = bus.b_wdata;
    if (aw && bus.a_we && bus.a_addr < 256) ref_mem[bus.a_addr[7:2]] = bus.a_wdata;
    if (!reset) begin
      m_ack = 0; m_lost = 0; m_brd = 0;
    end else begin
      if (bw) m_brd = rd;
      m_lost = (be && aw) ? (m_lost < SM ? m_lost + 1 : SM) : 0;
      m_ack = bw;
    end
    a_hold = bus.a_req && !aw;
    b_hold = bus.b_req && !bw;
  end
  always @(negedge clk) if (chk_en) begin : compare
    bit be, bw, aw;
    decide(be, bw, aw);
    check("mem_addr", bus.mem_addr, bw ? bus.b_addr : aw ? bus.a_addr : 32'h0);
    check("mem_wdata", bus.mem_wdata, bw ? bus.b_wdata : aw ? bus.a_wdata : 32'h0);
    check("mem_read", 32'(bus.mem_read), 32'((aw && !bus.a_we) || (bw && !bus.b_we)));
    check("mem_write", 32'(bus.mem_write), 32'((aw && bus.a_we) || (bw && bus.b_we)));
    check("a_rdata", bus.a_rdata, (aw && !bus.a_we) ? mrd(bus.a_addr) : 32'h0);
    check("a_stall", 32'(bus.a_stall), 32'(bus.a_req && !aw));
    check("b_ack", 32'(bus.b_ack), 32'(m_ack && reset));
    check("b_rdata", bus.b_rdata, m_brd);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pick();
    return $urandom_range(0, 9) == 0 ? 32'h1000 : 32'h40 + 4 * $urandom_range(0, 3);
  endfunction
  initial begin
    int acks;
    for (int i = 0; i < 64; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    mem[2] = 32'h4F; ref_mem[2] = 32'h4F;
    {bus.a_req, bus.a_we, bus.b_req, bus.b_we} = '0;
    {bus.a_addr, bus.a_wdata, bus.b_addr, bus.b_wdata} = '0;
    step();
    chk_en = 1;
    @(negedge clk);
    check("rst_b_ack", 32'(bus.b_ack), 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_mem_write", 32'(bus.mem_write), 0);
    check("rst_a_stall", 32'(bus.a_stall), 0);
    step();
    reset = 1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h8;
    @(negedge clk);
    check("a_only_rdata", bus.a_rdata, 32'h4F);
    check("a_only_stall", 32'(bus.a_stall), 0);
    check("a_only_read", 32'(bus.mem_read), 1);
    step();
    bus.a_req = 0;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h40; bus.b_wdata = 32'h55;
    @(negedge clk);
    check("b_wr_write", 32'(bus.mem_write), 1);
    step();
    bus.b_we = 0;
    @(negedge clk);
    check("b_wr_ack", 32'(bus.b_ack), 1);
    step();
    @(negedge clk);
    check("b_rd_read", 32'(bus.mem_read), 1);
    step();
    bus.b_req = 0;
    @(negedge clk);
    check("b_rd_ack", 32'(bus.b_ack), 1);
    check("b_rd_data", bus.b_rdata, 32'h55);
    step();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h8;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("starve_stall", 32'(bus.a_stall), 32'(i == 2));
      check("starve_ack", 32'(bus.b_ack), 32'(i == 3));
      step();
      if (i == 2) bus.b_req = 0;
    end
    bus.a_req = 0;
    step();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h44; bus.a_wdata = 32'h11;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h44; bus.b_wdata = 32'h22;
    @(negedge clk);
    check("ww_a_first", bus.mem_wdata, 32'h11);
    step();
    @(negedge clk);
    check("ww_word_a", mem[17], 32'h11);
    step();
    @(negedge clk);
    check("ww_a_stall", 32'(bus.a_stall), 1);
    check("ww_b_data", bus.mem_wdata, 32'h22);
    step();
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    check("ww_b_ack", 32'(bus.b_ack), 1);
    check("ww_word_b", mem[17], 32'h22);
    step();
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h48;
    @(negedge clk);
    check("rst_mid_grant", 32'(bus.mem_read), 1);
    step();
    reset = 0;
    @(negedge clk);
    check("rst_mid_noack", 32'(bus.b_ack), 0);
    step();
    reset = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.b_ack) acks++;
      step();
      if (acks > 0) bus.b_req = 0;
    end
    check("rst_mid_one_ack", 32'(acks), 1);
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 39) != 0;
      if (!a_hold) begin
        bus.a_req = $urandom_range(0, 1); bus.a_we = $urandom_range(0, 1);
        bus.a_addr = pick(); bus.a_wdata = $urandom;
      end
      if (!b_hold) begin
        bus.b_req = $urandom_range(0, 1); bus.b_we = $urandom_range(0, 1);
        bus.b_addr = pick(); bus.b_wdata = $urandom;
      end
      step();
    end
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
